// File: rtl/memu_if.sv
// rtl/memu_if.sv - EXE->MEM->WB handshake, SRAM read data and forwarding bundle
interface memu_if;
  localparam int EXE2MEM_LEN = 75;
  localparam int MEM2WB_LEN  = 70;

  logic                   mem_allowin;
  logic                   exe_to_mem_valid;
  logic [EXE2MEM_LEN-1:0] exe_to_mem_zip;
  logic                   wb_allowin;
  logic                   mem_to_wb_valid;
  logic [MEM2WB_LEN-1:0]  mem_to_wb_zip;
  logic [31:0]            data_sram_rdata;
  logic [37:0]            mem_rf_zip;

  modport master (
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_zip, mem_rf_zip,
    output exe_to_mem_valid, exe_to_mem_zip, wb_allowin, data_sram_rdata
  );

  modport slave (
    output mem_allowin, mem_to_wb_valid, mem_to_wb_zip, mem_rf_zip,
    input  exe_to_mem_valid, exe_to_mem_zip, wb_allowin, data_sram_rdata
  );
endinterface

// File: rtl/memu.sv
// rtl/memu.sv - memory-access pipeline stage; optional load-data buffer under MEM_RDATA_BUF_EN
module memu (
  input  logic   clk,
  input  logic   resetn,
  memu_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FIRST = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        res_from_mem_q, res_from_mem_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [3:0]  mem_op_q, mem_op_d;
  logic [31:0] pc_q, pc_d;

  logic        mem_valid;
  logic        mem_ready_go;
  logic        accept;
  logic        drain;
  logic [31:0] rdata_src;
  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] result;

  assign mem_valid    = (state_q != S_EMPTY);
  assign mem_ready_go = 1'b1;

  assign bus.mem_allowin     = ~mem_valid | (mem_ready_go & bus.wb_allowin);
  assign bus.mem_to_wb_valid = mem_valid & mem_ready_go;

  assign accept = bus.exe_to_mem_valid & bus.mem_allowin;
  assign drain  = bus.mem_to_wb_valid & bus.wb_allowin;

  always_comb begin
    state_d        = state_q;
    res_from_mem_d = res_from_mem_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    alu_result_d   = alu_result_q;
    mem_op_d       = mem_op_q;
    pc_d           = pc_q;
    if (accept) begin
      state_d = S_FIRST;
      {res_from_mem_d, rf_we_d, rf_waddr_d, alu_result_d, mem_op_d, pc_d} = bus.exe_to_mem_zip;
    end else if (drain) begin
      state_d = S_EMPTY;
    end else if (mem_valid) begin
      state_d = S_HOLD;
    end else begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_EMPTY;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= 5'd0;
      alu_result_q   <= 32'd0;
      mem_op_q       <= 4'd0;
      pc_q           <= 32'd0;
    end else begin
      state_q        <= state_d;
      res_from_mem_q <= res_from_mem_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      alu_result_q   <= alu_result_d;
      mem_op_q       <= mem_op_d;
      pc_q           <= pc_d;
    end
  end

`ifdef MEM_RDATA_BUF_EN
  // SRAM data is only live in FIRST; keep a copy so a stalled load still sees it.
  logic [31:0] rdata_buf_q, rdata_buf_d;

  always_comb begin
    rdata_buf_d = rdata_buf_q;
    if (state_q == S_FIRST) begin
      rdata_buf_d = bus.data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_buf_q <= 32'd0;
    end else begin
      rdata_buf_q <= rdata_buf_d;
    end
  end

  assign rdata_src = (state_q == S_HOLD) ? rdata_buf_q : bus.data_sram_rdata;
`else
  assign rdata_src = bus.data_sram_rdata;
`endif

  assign lane    = alu_result_q[1:0];
  assign ld_byte = 8'(rdata_src >> {lane, 3'b000});
  assign ld_half = lane[1] ? rdata_src[31:16] : rdata_src[15:0];

  always_comb begin
    load_data = 32'd0;
    case (mem_op_q)
      4'd0:    load_data = {{24{ld_byte[7]}}, ld_byte};
      4'd1:    load_data = {{16{ld_half[15]}}, ld_half};
      4'd2:    load_data = rdata_src;
      4'd8:    load_data = {24'd0, ld_byte};
      4'd9:    load_data = {16'd0, ld_half};
      default: load_data = 32'd0;
    endcase
  end

  assign result = res_from_mem_q ? load_data : alu_result_q;

  assign bus.mem_to_wb_zip = {rf_we_q, rf_waddr_q, result, pc_q};
  assign bus.mem_rf_zip    = {mem_valid & rf_we_q, rf_waddr_q, result};

endmodule

// File: tb/tb_memu.sv
// tb/tb_memu.sv - vector table, directed corner sequences and random model check for memu
module tb_memu;

  logic clk;
  logic resetn;
  int   n_pass;
  int   n_total;

  memu_if bus();

  memu dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MEM_RDATA_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        rfm;
    logic        we;
    logic [3:0]  op;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp_res;
  } vec_t;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [74:0] mkzip(logic rfm, logic we, logic [4:0] wa,
                                        logic [31:0] alu, logic [3:0] op, logic [31:0] pc);
    return {rfm, we, wa, alu, op, pc};
  endfunction

  // Reference: select lane by arithmetic shift, extend via signed assignment.
  function automatic logic [31:0] ref_result(logic rfm, logic [3:0] op, logic [31:0] alu, logic [31:0] w);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] ext;
    if (!rfm) return alu;
    b  = 8'((w >> (8 * alu[1:0])) & 32'hFF);
    h  = alu[1] ? 16'(w / 65536) : 16'(w % 65536);
    sb = b;
    sh = h;
    case (op)
      4'd0: begin ext = sb; return ext; end
      4'd1: begin ext = sh; return ext; end
      4'd2: return w;
      4'd8: return 32'(b);
      4'd9: return 32'(h);
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.exe_to_mem_valid = 1'b0;
    bus.exe_to_mem_zip   = '0;
    bus.wb_allowin       = 1'b1;
    bus.data_sram_rdata  = '0;
  endtask

  vec_t vecs[10];
  logic        mv, first, cur_rfm, cur_we, ev, wb, exp_allow;
  logic [3:0]  cur_op;
  logic [4:0]  cur_wa;
  logic [31:0] cur_alu, cur_pc, word, exp_r;
  logic [74:0] nz;
  logic [3:0]  ops[9];

  initial begin
    n_pass  = 0;
    n_total = 0;
    resetn  = 1'b0;
    idle_inputs();
    bus.wb_allowin = 1'b0;

    vecs[0] = '{"ld_b_a3",   1, 1, 4'd0, 32'h1003, 32'h80FF_1234, 32'hFFFF_FF80};
    vecs[1] = '{"ld_bu_a3",  1, 1, 4'd8, 32'h1003, 32'h80FF_1234, 32'h0000_0080};
    vecs[2] = '{"ld_h_a2",   1, 0, 4'd1, 32'h2002, 32'h8001_7FFF, 32'hFFFF_8001};
    vecs[3] = '{"ld_hu_a0",  1, 1, 4'd9, 32'h2000, 32'h8001_7FFF, 32'h0000_7FFF};
    vecs[4] = '{"ld_w",      1, 1, 4'd2, 32'h2000, 32'h8001_7FFF, 32'h8001_7FFF};
    vecs[5] = '{"ld_b_a1",   1, 1, 4'd0, 32'h0001, 32'h80FF_1234, 32'h0000_0012};
    vecs[6] = '{"ld_hu_a3",  1, 1, 4'd9, 32'h0003, 32'h80FF_1234, 32'h0000_80FF};
    vecs[7] = '{"st_w_pass", 0, 0, 4'd6, 32'h0000_1234, 32'hAAAA_5555, 32'h0000_1234};
    vecs[8] = '{"ld_undef",  1, 1, 4'd3, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[9] = '{"ld_b_a2",   1, 1, 4'd0, 32'h0000_0002, 32'h807F_0000, 32'h0000_007F};

    // Reset held 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_allowin", 70'(bus.mem_allowin), 70'd1);
    check("rst_valid",   70'(bus.mem_to_wb_valid), 70'd0);
    check("rst_wb_zip",  70'(bus.mem_to_wb_zip), 70'd0);
    check("rst_rf_zip",  70'(bus.mem_rf_zip), 70'd0);
    resetn = 1'b1;
    bus.wb_allowin = 1'b1;

    // Vector table: one instruction per vector, rdata supplied in its MEM cycle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.exe_to_mem_valid = 1'b1;
      bus.exe_to_mem_zip   = mkzip(vecs[i].rfm, vecs[i].we, 5'(i + 1), vecs[i].alu, vecs[i].op, 32'h100 + 32'(i));
      bus.data_sram_rdata  = $urandom;
      @(negedge clk);
      bus.exe_to_mem_valid = 1'b0;
      bus.data_sram_rdata  = vecs[i].rdata;
      #1;
      check({vecs[i].name, "_valid"}, 70'(bus.mem_to_wb_valid), 70'd1);
      check({vecs[i].name, "_result"}, 70'(bus.mem_to_wb_zip[63:32]), 70'(vecs[i].exp_res));
      check({vecs[i].name, "_fwd"}, 70'(bus.mem_rf_zip), 70'({vecs[i].we, 5'(i + 1), vecs[i].exp_res}));
      check({vecs[i].name, "_pc"}, 70'(bus.mem_to_wb_zip[31:0]), 70'(32'h100 + 32'(i)));
    end

    // Back-to-back add, st.w, ld.w
    @(negedge clk);
    check("b2b_idle", 70'(bus.mem_to_wb_valid), 70'd0);
    bus.exe_to_mem_valid = 1'b1;
    bus.exe_to_mem_zip   = mkzip(1'b0, 1'b1, 5'd3, 32'h5, 4'd0, 32'h400);
    @(negedge clk);
    bus.exe_to_mem_zip   = mkzip(1'b0, 1'b0, 5'd0, 32'h0000_0100, 4'd6, 32'h404);
    #1;
    check("b2b_add_valid", 70'(bus.mem_to_wb_valid), 70'd1);
    check("b2b_add_zip", 70'(bus.mem_to_wb_zip), {1'b1, 5'd3, 32'h5, 32'h400});
    @(negedge clk);
    bus.exe_to_mem_zip   = mkzip(1'b1, 1'b1, 5'd7, 32'h0000_0200, 4'd2, 32'h408);
    #1;
    check("b2b_st_valid", 70'(bus.mem_to_wb_valid), 70'd1);
    check("b2b_st_zip", 70'(bus.mem_to_wb_zip), {1'b0, 5'd0, 32'h100, 32'h404});
    @(negedge clk);
    bus.exe_to_mem_valid = 1'b0;
    bus.data_sram_rdata  = 32'hCAFE_F00D;
    #1;
    check("b2b_ld_valid", 70'(bus.mem_to_wb_valid), 70'd1);
    check("b2b_ld_zip", 70'(bus.mem_to_wb_zip), {1'b1, 5'd7, 32'hCAFE_F00D, 32'h408});
    @(negedge clk); #1;
    check("b2b_drained", 70'(bus.mem_to_wb_valid), 70'd0);

`ifdef MEM_RDATA_BUF_EN
    // Stalled load keeps its buffered data; upstream junk is ignored
    @(negedge clk);
    bus.exe_to_mem_valid = 1'b1;
    bus.exe_to_mem_zip   = mkzip(1'b1, 1'b1, 5'd9, 32'h300, 4'd2, 32'h500);
    @(negedge clk);
    bus.data_sram_rdata  = 32'hDEAD_BEEF;
    bus.wb_allowin       = 1'b0;
    bus.exe_to_mem_zip   = mkzip(1'b0, 1'b1, 5'd1, 32'h1, 4'd0, 32'h600);
    #1;
    check("buf_first_res", 70'(bus.mem_to_wb_zip[63:32]), 70'(32'hDEAD_BEEF));
    check("buf_first_allow", 70'(bus.mem_allowin), 70'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.data_sram_rdata = 32'h0;
      bus.wb_allowin      = (k == 2) ? 1'b1 : 1'b0;
      if (k == 2) bus.exe_to_mem_valid = 1'b0;
      #1;
      check("buf_hold_res", 70'(bus.mem_to_wb_zip), {1'b1, 5'd9, 32'hDEAD_BEEF, 32'h500});
      check("buf_hold_valid", 70'(bus.mem_to_wb_valid), 70'd1);
      check("buf_hold_allow", 70'(bus.mem_allowin), 70'(k == 2));
    end
    @(negedge clk); #1;
    check("buf_one_handoff", 70'(bus.mem_to_wb_valid), 70'd0);
`endif

    // Reset while a load is held
    @(negedge clk);
    bus.exe_to_mem_valid = 1'b1;
    bus.exe_to_mem_zip   = mkzip(1'b1, 1'b1, 5'd4, 32'h700, 4'd2, 32'h800);
    @(negedge clk);
    bus.exe_to_mem_valid = 1'b0;
    bus.wb_allowin       = 1'b0;
    @(negedge clk); #1;
    check("hold_valid", 70'(bus.mem_to_wb_valid), 70'd1);
    resetn = 1'b0;
    @(negedge clk); #1;
    check("rst_hold_valid", 70'(bus.mem_to_wb_valid), 70'd0);
    check("rst_hold_zip", 70'(bus.mem_to_wb_zip), 70'd0);
    check("rst_hold_fwd", 70'(bus.mem_rf_zip), 70'd0);
    resetn = 1'b1;
    bus.wb_allowin = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("rst_no_handoff", 70'(bus.mem_to_wb_valid), 70'd0);
    end

    // Random traffic against an instruction-level model
    ops = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd4, 4'd5, 4'd6, 4'd3};
    mv = 1'b0; first = 1'b0; word = '0;
    cur_rfm = 0; cur_we = 0; cur_op = 0; cur_wa = 0; cur_alu = 0; cur_pc = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      ev = 1'($urandom_range(0, 1));
      wb = ($urandom_range(0, 3) != 0);
      nz = mkzip(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
                 $urandom, ops[$urandom_range(0, 8)], $urandom);
      bus.exe_to_mem_valid = ev;
      bus.exe_to_mem_zip   = nz;
      bus.wb_allowin       = wb;
      bus.data_sram_rdata  = (mv && first) ? word : $urandom;
      #1;
      exp_allow = !mv || wb;
      check("rnd_allowin", 70'(bus.mem_allowin), 70'(exp_allow));
      check("rnd_valid", 70'(bus.mem_to_wb_valid), 70'(mv));
      if (mv) begin
        check("rnd_ctl", 70'({bus.mem_to_wb_zip[69:64], bus.mem_to_wb_zip[31:0]}),
              70'({cur_we, cur_wa, cur_pc}));
        check("rnd_fwd_we", 70'(bus.mem_rf_zip[37:32]), 70'({cur_we, cur_wa}));
        if (first || !cur_rfm || BUF_EN) begin
          exp_r = ref_result(cur_rfm, cur_op, cur_alu, word);
          check("rnd_result", 70'(bus.mem_to_wb_zip[63:32]), 70'(exp_r));
          check("rnd_fwd_res", 70'(bus.mem_rf_zip[31:0]), 70'(exp_r));
        end
      end
      @(posedge clk);
      if (ev && exp_allow) begin
        {cur_rfm, cur_we, cur_wa, cur_alu, cur_op, cur_pc} = nz;
        mv = 1'b1; first = 1'b1; word = $urandom;
      end else if (mv && wb) begin
        mv = 1'b0; first = 1'b0;
      end else begin
        first = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
